// File: rtl/arduino_irq_handshake.sv
// Turns a rising edge on the PIO request line into a fixed-width interrupt pulse,
// waits for the Arduino acknowledge with a timeout, and reports the outcome on Avalon s1.
module arduino_irq_handshake #(
    parameter int PULSE_CYCLES   = 100,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        irq_req,
    input  logic        arduino_ack,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq_out
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_ACK
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   pulse_cnt, pulse_cnt_nxt;
    logic [TW-1:0]   to_cnt, to_cnt_nxt;
    logic            ack_pend, ack_pend_nxt;

    logic            irq_req_d;
    logic            ack_m, ack_s, ack_s_d;
    logic            req_edge, ack_edge;

    logic            acked, timeout, overrun;
    logic [CNT_W-1:0] ack_cnt, to_evt_cnt;

    logic            wr, wr_status, wr_ctrl, abort, cnt_clr;
    logic            set_ack, set_to, set_ovr;
    logic            unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wr_status = wr && (address == 2'd0);
    assign wr_ctrl   = wr && (address == 2'd3);
    assign abort     = wr_ctrl & writedata[1];
    assign cnt_clr   = wr_ctrl & writedata[0];
    assign unused_wd = ^writedata[31:4];

    assign req_edge  = irq_req & ~irq_req_d;
    assign ack_edge  = ack_s & ~ack_s_d;
    assign set_ovr   = req_edge && (state != IDLE);

    assign irq_out   = (state == PULSE);

    // arduino_ack is asynchronous: two flops before edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_req_d <= 1'b0;
            ack_m     <= 1'b0;
            ack_s     <= 1'b0;
            ack_s_d   <= 1'b0;
        end else begin
            irq_req_d <= irq_req;
            ack_m     <= arduino_ack;
            ack_s     <= ack_m;
            ack_s_d   <= ack_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pulse_cnt <= '0;
            to_cnt    <= '0;
            ack_pend  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pulse_cnt <= pulse_cnt_nxt;
            to_cnt    <= to_cnt_nxt;
            ack_pend  <= ack_pend_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pulse_cnt_nxt = pulse_cnt;
        to_cnt_nxt    = to_cnt;
        ack_pend_nxt  = ack_pend;
        set_ack       = 1'b0;
        set_to        = 1'b0;
        if (abort) begin
            state_nxt    = IDLE;
            ack_pend_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_edge) begin
                        state_nxt     = PULSE;
                        pulse_cnt_nxt = PW'(PULSE_CYCLES - 1);
                    end
                end
                PULSE: begin
                    // an early ack is remembered so the pulse keeps its full width
                    if (ack_edge)
                        ack_pend_nxt = 1'b1;
                    if (pulse_cnt == '0) begin
                        state_nxt  = WAIT_ACK;
                        to_cnt_nxt = TW'(TIMEOUT_CYCLES - 1);
                    end else begin
                        pulse_cnt_nxt = pulse_cnt - PW'(1);
                    end
                end
                WAIT_ACK: begin
                    if (ack_edge || ack_pend) begin
                        state_nxt    = IDLE;
                        ack_pend_nxt = 1'b0;
                        set_ack      = 1'b1;
                    end else if (to_cnt == '0) begin
                        state_nxt = IDLE;
                        set_to    = 1'b1;
                    end else begin
                        to_cnt_nxt = to_cnt - TW'(1);
                    end
                end
                default: begin
                    state_nxt    = IDLE;
                    ack_pend_nxt = 1'b0;
                end
            endcase
        end
    end

    // sticky status: W1C clear, a same-cycle set wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acked   <= 1'b0;
            timeout <= 1'b0;
            overrun <= 1'b0;
        end else begin
            acked   <= (acked   & ~(wr_status & writedata[1])) | set_ack;
            timeout <= (timeout & ~(wr_status & writedata[2])) | set_to;
            overrun <= (overrun & ~(wr_status & writedata[3])) | set_ovr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_cnt    <= '0;
            to_evt_cnt <= '0;
        end else begin
            if (cnt_clr)
                ack_cnt <= set_ack ? CNT_W'(1) : '0;
            else if (set_ack && (ack_cnt != '1))
                ack_cnt <= ack_cnt + CNT_W'(1);

            if (cnt_clr)
                to_evt_cnt <= set_to ? CNT_W'(1) : '0;
            else if (set_to && (to_evt_cnt != '1))
                to_evt_cnt <= to_evt_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = {28'd0, overrun, timeout, acked, state != IDLE};
            2'd1:    readdata = 32'(ack_cnt);
            2'd2:    readdata = 32'(to_evt_cnt);
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_arduino_irq_handshake.sv
// Bench for arduino_irq_handshake: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_arduino_irq_handshake;

    localparam int P  = 4;
    localparam int T  = 16;
    localparam int CW = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        irq_req = 1'b0;
    logic        arduino_ack = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    arduino_irq_handshake #(
        .PULSE_CYCLES  (P),
        .TIMEOUT_CYCLES(T),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .irq_req    (irq_req),
        .arduino_ack(arduino_ack),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_out    (irq_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request accepted at edge 'start' owns edges start+1..start+P
    // as pulse cycles and start+P+1..start+P+T as acknowledge-window cycles.
    int e = 0, start = 0;
    bit active = 0, pend = 0;
    bit m_acked = 0, m_to = 0, m_ovr = 0;
    int m_ack_cnt = 0, m_to_cnt = 0;
    bit h0 = 0, h1 = 0, h2 = 0, rprev = 0;

    always @(posedge clk or negedge reset_n) begin
        bit ack_e, req_e, wr, abort, clr, sa, st;
        int k;
        if (!reset_n) begin
            active = 0; pend = 0; start = e;
            m_acked = 0; m_to = 0; m_ovr = 0;
            m_ack_cnt = 0; m_to_cnt = 0;
            h0 = 0; h1 = 0; h2 = 0; rprev = 0;
        end else begin
            e++;
            ack_e = h1 & ~h2;
            req_e = irq_req & ~rprev;
            wr    = chipselect & ~write_n;
            abort = wr && address == 2'd3 && writedata[1];
            clr   = wr && address == 2'd3 && writedata[0];
            sa = 0; st = 0;
            k = e - start;
            if (wr && address == 2'd0) begin
                if (writedata[1]) m_acked = 0;
                if (writedata[2]) m_to = 0;
                if (writedata[3]) m_ovr = 0;
            end
            if (active) begin
                if (req_e) m_ovr = 1;
                if (abort) begin
                    active = 0; pend = 0;
                end else if (k <= P) begin
                    if (ack_e) pend = 1;
                end else if (ack_e || pend) begin
                    active = 0; pend = 0; sa = 1;
                end else if (k == P + T) begin
                    active = 0; st = 1;
                end
            end else if (req_e && !abort) begin
                active = 1; start = e;
            end
            if (sa) m_acked = 1;
            if (st) m_to = 1;
            if (clr) begin m_ack_cnt = 0; m_to_cnt = 0; end
            if (sa && m_ack_cnt < CNT_MAX) m_ack_cnt++;
            if (st && m_to_cnt < CNT_MAX) m_to_cnt++;
            h2 = h1; h1 = h0; h0 = arduino_ack;
            rprev = irq_req;
        end
    end

    function automatic logic m_irq();
        return active && ((e - start) < P);
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ovr, m_to, m_acked, active};
            2'd1:    return 32'(m_ack_cnt);
            2'd2:    return 32'(m_to_cnt);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            check("irq_out_model", {31'd0, irq_out}, {31'd0, m_irq()});
            check("readdata_model", readdata, m_read(address));
        end
    end

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a;
        #1 d = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; writedata = '0; address = 2'd0;
    endtask

    // Raise irq_req and observe n cycles; indices count clock edges from the request edge (1).
    task automatic run(input int n, input int ack_at, input int low_at, input int rise2_at,
                       output int first_hi, output int hi_cnt, output int wait_cnt,
                       output int rises);
        bit prev = 0;
        first_hi = -1; hi_cnt = 0; wait_cnt = 0; rises = 0;
        @(negedge clk);
        address = 2'd0;
        irq_req = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (irq_out) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
                if (!prev) rises++;
            end
            if (!irq_out && readdata[0]) wait_cnt++;
            prev = irq_out;
            #1;
            if (i == ack_at)   arduino_ack = 1'b1;
            if (i == low_at)   irq_req = 1'b0;
            if (i == rise2_at) irq_req = 1'b1;
        end
        @(negedge clk);
        irq_req = 1'b0;
        arduino_ack = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        int fh, hc, wc, rc;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        check("t1_irq_out", {31'd0, irq_out}, 32'd0);
        rd(2'd0, d); check("t1_status", d, 32'h0);
        rd(2'd1, d); check("t1_ack_cnt", d, 32'h0);
        rd(2'd2, d); check("t1_to_cnt", d, 32'h0);

        // ack arrives well after the pulse
        run(20, 9, 0, 0, fh, hc, wc, rc);
        check("t2_first_hi", 32'(fh), 32'd1);
        check("t2_width", 32'(hc), 32'd4);
        check("t2_wait", 32'(wc), 32'd7);
        rd(2'd0, d); check("t2_status", d, 32'h2);
        rd(2'd1, d); check("t2_ack_cnt", d, 32'h1);

        // no ack: full timeout window
        wr(2'd0, 32'hE);
        run(30, 0, 0, 0, fh, hc, wc, rc);
        check("t3_width", 32'(hc), 32'd4);
        check("t3_wait", 32'(wc), 32'd16);
        rd(2'd0, d); check("t3_status", d, 32'h4);
        rd(2'd2, d); check("t3_to_cnt", d, 32'h1);

        // ack during pulse
        wr(2'd0, 32'hE);
        run(20, 1, 0, 0, fh, hc, wc, rc);
        check("t4_width", 32'(hc), 32'd4);
        check("t4_wait", 32'(wc), 32'd1);
        rd(2'd0, d); check("t4_status", d, 32'h2);
        rd(2'd1, d); check("t4_ack_cnt", d, 32'h2);

        // second request during the ack window
        wr(2'd0, 32'hE);
        run(30, 0, 2, 7, fh, hc, wc, rc);
        check("t5_rises", 32'(rc), 32'd1);
        check("t5_width", 32'(hc), 32'd4);
        rd(2'd0, d); check("t5_status", d, 32'hC);
        wr(2'd0, 32'hE);
        rd(2'd0, d); check("t5_status_clr", d, 32'h0);
        rd(2'd2, d); check("t5_to_cnt", d, 32'h2);

        // asynchronous reset in the middle of a pulse
        @(negedge clk);
        irq_req = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check("t6_irq_before", {31'd0, irq_out}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check("t6_irq_async", {31'd0, irq_out}, 32'd0);
        irq_req = 1'b0;
        rd(2'd0, d); check("t6_status", d, 32'h0);
        rd(2'd1, d); check("t6_ack_cnt", d, 32'h0);
        rd(2'd2, d); check("t6_to_cnt", d, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run(20, 9, 0, 0, fh, hc, wc, rc);
        check("t6_first_hi", 32'(fh), 32'd1);
        check("t6_width", 32'(hc), 32'd4);
        rd(2'd0, d); check("t6_status_after", d, 32'h2);
        rd(2'd1, d); check("t6_ack_cnt_after", d, 32'h1);

        // abort mid-pulse, then counter clear
        wr(2'd0, 32'hE);
        @(negedge clk);
        irq_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_irq_before", {31'd0, irq_out}, 32'd1);
        wr(2'd3, 32'h2);
        check("abort_irq_after", {31'd0, irq_out}, 32'd0);
        irq_req = 1'b0;
        rd(2'd0, d); check("abort_status", d, 32'h0);
        wr(2'd3, 32'h1);
        rd(2'd1, d); check("clr_ack_cnt", d, 32'h0);
        rd(2'd2, d); check("clr_to_cnt", d, 32'h0);
        rd(2'd3, d); check("ctrl_read", d, 32'h0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
